vga_timing_monitor: RTL and testbench
=====================================

Name: vga_timing_monitor

Overview:
- Sink-side checker for the VGA link driven by the team's image generators and VGA controller.
- Samples VGA_HS/VGA_VS/RGB on the pixel clock and measures horizontal total, hsync width, vertical total and vsync width.
- Counts lines containing non-black pixels and flags timing deviations from the expected mode.
- Used in simulation benches and on-board self-test to validate generator output.

Parameters:
- H_TOTAL, 800, expected pixel clocks per line
- H_SYNC, 96, expected hsync width in pixel clocks
- V_TOTAL, 525, expected lines per frame
- V_SYNC, 2, expected vsync width in lines
- SYNC_POL, 0, sync polarity (0 = active-low, 1 = active-high)
- CNT_W, 12, width of all counters and measurement outputs

Ports:
- pixel_clk  input  1  pixel clock (25 MHz); all logic rising-edge
- rst  input  1  asynchronous, active-low reset
- VGA_HS  input  1  horizontal sync from generator
- VGA_VS  input  1  vertical sync from generator
- VGA_R  input  4  red channel
- VGA_G  input  4  green channel
- VGA_B  input  4  blue channel
- err_clr  input  1  synchronous pulse, clears timing_err
- h_total_meas  output  CNT_W  last measured line period, pixel clocks
- h_sync_meas  output  CNT_W  last measured hsync width, pixel clocks
- v_total_meas  output  CNT_W  last measured frame length, lines
- v_sync_meas  output  CNT_W  last measured vsync width, lines
- lit_lines  output  CNT_W  lines in last frame with any nonzero RGB
- frame_done  output  1  one-cycle pulse when a full frame is measured
- locked  output  1  two consecutive frames matched all parameters
- timing_err  output  1  sticky: a completed frame mismatched

Behaviour:
- Reset (rst low, async): all outputs 0; all counters, synchronizers, edge history and seen-flags cleared.
- Input stage: HS, VS and the 12 RGB bits each pass through a 2-FF synchronizer. This gives a uniform 2-cycle latency, so measured values are unaffected.
- Polarity: hs_act = sync_hs XOR (SYNC_POL==0); vs_act likewise.
- Edges:
  - hs_start = hs_act & ~hs_act_d; hs_end = ~hs_act & hs_act_d.
  - vs_start and vs_end are defined the same way on vs_act.
- Horizontal:
  - h_cnt increments every cycle and saturates at all-ones.
  - On hs_start: if h_seen, h_total_meas <= h_cnt+1; then h_cnt <= 0 and h_seen <= 1.
  - hs_w counts cycles while hs_act (saturating). On hs_end: if h_seen, h_sync_meas <= hs_w; hs_w <= 0.
- Line activity: line_lit sets on any cycle with synchronized RGB != 0. On hs_start: lit_cnt += line_lit, then line_lit <= 0.
- Vertical (line units):
  - v_cnt increments on hs_start.
  - On vs_start: v_total_meas <= v_cnt + hs_start; lit_lines <= lit_cnt + (hs_start & line_lit); v_cnt <= 0; lit_cnt <= 0.
  - A coincident hs_start therefore closes the ending frame. Latch outputs only if v_seen; set v_seen.
- Vsync width:
  - On vs_start: vs_w <= hs_start; otherwise, if vs_act & hs_start, vs_w += 1.
  - On vs_end: v_sync_meas <= vs_w (only if v_seen).
  - Consequence: an hs_start coincident with vs_end is not counted (vs_act already low).
- Per-frame check: frame_bad sets whenever a latched h_total_meas != H_TOTAL or h_sync_meas != H_SYNC. It clears on vs_start after evaluation.
- frame_done pulses one cycle after a vs_start that latched outputs (v_seen was already 1). That cycle evaluates the frame: good = !frame_bad & v_total==V_TOTAL & v_sync_meas(previous frame)==V_SYNC.
- locked:
  - A good frame increments good_run (saturate at 2); locked <= (good_run reaches 2).
  - A bad frame: good_run <= 0, locked <= 0, timing_err <= 1.
- Loss of sync: h_cnt saturating (no hsync) clears locked and good_run and sets timing_err; h_seen and v_seen clear, so the next line and frame are discarded.
- err_clr: clears timing_err. If the same cycle flags a bad frame, set wins.
- Saturation: all counters stick at 2^CNT_W-1, never wrap.
- Reset mid-frame: the partial line and frame after release are never reported. The first frame_done arrives at the second vs_start.

Test Plan:
- Nominal 640x480@60 stimulus (800/96/525/2, active-low, 480 coloured lines), 3 frames -> h_total_meas=800, h_sync_meas=96, v_total_meas=525, v_sync_meas=2, lit_lines=480. frame_done pulses at vs_start #2 and #3; locked=1 after the second pulse; timing_err=0.
- One line with hsync width 95 in frame 3 -> h_sync_meas=95; at that frame's frame_done locked=0, timing_err=1. err_clr pulse -> timing_err=0; relock after 2 good frames.
- SYNC_POL=1 with inverted sync stimulus -> identical measurements to the nominal case.
- RGB black on lines 0-159 of the active area, coloured elsewhere -> lit_lines=320.
- HS held inactive for 4096+ cycles -> locked=0, timing_err=1. After HS resumes, first h_total_meas update is on the second hs_start.
- rst low mid-frame for 3 cycles -> all outputs 0 immediately. No frame_done until the second vs_start after release; its values are 800/96/525/2.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// Sink-side VGA timing checker: measures line/frame geometry from HS/VS/RGB,
// counts lit lines per frame, and tracks lock / sticky timing-error status.
module vga_timing_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 12
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic [3:0]       VGA_R,
  input  logic [3:0]       VGA_G,
  input  logic [3:0]       VGA_B,
  input  logic             err_clr,
  output logic [CNT_W-1:0] h_total_meas,
  output logic [CNT_W-1:0] h_sync_meas,
  output logic [CNT_W-1:0] v_total_meas,
  output logic [CNT_W-1:0] v_sync_meas,
  output logic [CNT_W-1:0] lit_lines,
  output logic             frame_done,
  output logic             locked,
  output logic             timing_err
);

  localparam logic             INV       = (SYNC_POL == 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] H_TOTAL_C = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_TOTAL_C = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Sync inputs are polarity-normalised before the synchronizer, so the
  // cleared state reads as "inactive" and reset release creates no edges.
  logic [13:0] in_raw;
  logic [13:0] in_s1;
  logic [13:0] in_s2;
  logic        hs_act_d;
  logic        vs_act_d;

  assign in_raw = {VGA_HS ^ INV, VGA_VS ^ INV, VGA_R, VGA_G, VGA_B};

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      in_s1    <= '0;
      in_s2    <= '0;
      hs_act_d <= 1'b0;
      vs_act_d <= 1'b0;
    end else begin
      in_s1    <= in_raw;
      in_s2    <= in_s1;
      hs_act_d <= in_s2[13];
      vs_act_d <= in_s2[12];
    end
  end

  logic hs_act, vs_act, rgb_nz;
  logic hs_start, hs_end, vs_start, vs_end;

  assign hs_act   = in_s2[13];
  assign vs_act   = in_s2[12];
  assign rgb_nz   = |in_s2[11:0];
  assign hs_start = hs_act & ~hs_act_d;
  assign hs_end   = ~hs_act & hs_act_d;
  assign vs_start = vs_act & ~vs_act_d;
  assign vs_end   = ~vs_act & vs_act_d;

  // Horizontal measurement
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] hs_w;
  logic             h_seen;
  logic             h_lost;
  logic             bad_now;

  assign h_lost  = (h_cnt == CNT_MAX) & ~hs_start;
  assign bad_now = (hs_start & h_seen & (sat_inc(h_cnt) != H_TOTAL_C)) |
                   (hs_end & h_seen & (hs_w != H_SYNC_C));

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      h_cnt        <= '0;
      hs_w         <= '0;
      h_seen       <= 1'b0;
      h_total_meas <= '0;
      h_sync_meas  <= '0;
    end else begin
      if (hs_start) begin
        if (h_seen) h_total_meas <= sat_inc(h_cnt);
        h_cnt  <= '0;
        h_seen <= 1'b1;
      end else begin
        h_cnt <= sat_inc(h_cnt);
        if (h_lost) h_seen <= 1'b0;
      end
      if (hs_end) begin
        if (h_seen) h_sync_meas <= hs_w;
        hs_w <= '0;
      end else if (hs_act) begin
        hs_w <= sat_inc(hs_w);
      end
    end
  end

  // Vertical measurement in line units; an hs_start coincident with vs_start
  // is the closing line of the ending frame.
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] lit_cnt;
  logic [CNT_W-1:0] vs_w;
  logic             v_seen;
  logic             line_lit;

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      v_cnt        <= '0;
      lit_cnt      <= '0;
      vs_w         <= '0;
      v_seen       <= 1'b0;
      line_lit     <= 1'b0;
      v_total_meas <= '0;
      v_sync_meas  <= '0;
      lit_lines    <= '0;
    end else begin
      line_lit <= hs_start ? 1'b0 : (line_lit | rgb_nz);
      if (vs_start) begin
        if (v_seen) begin
          v_total_meas <= hs_start ? sat_inc(v_cnt) : v_cnt;
          lit_lines    <= (hs_start & line_lit) ? sat_inc(lit_cnt) : lit_cnt;
        end
        v_cnt   <= '0;
        lit_cnt <= '0;
        v_seen  <= 1'b1;
        vs_w    <= CNT_W'(hs_start);
      end else begin
        if (hs_start) begin
          v_cnt <= sat_inc(v_cnt);
          if (line_lit) lit_cnt <= sat_inc(lit_cnt);
        end
        if (vs_act & hs_start) vs_w <= sat_inc(vs_w);
        if (h_lost) v_seen <= 1'b0;
      end
      if (vs_end & v_seen) v_sync_meas <= vs_w;
    end
  end

  // Frame evaluation runs in the frame_done cycle, once the vertical
  // measurements of the closed frame are visible in their registers.
  logic       frame_bad;
  logic       frame_bad_eval;
  logic [1:0] good_run;
  logic       frame_good;
  logic       eval_bad;

  assign frame_good = ~frame_bad_eval & (v_total_meas == V_TOTAL_C) &
                      (v_sync_meas == V_SYNC_C);
  assign eval_bad   = frame_done & ~frame_good;

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      frame_bad      <= 1'b0;
      frame_bad_eval <= 1'b0;
      frame_done     <= 1'b0;
      good_run       <= 2'd0;
      locked         <= 1'b0;
      timing_err     <= 1'b0;
    end else begin
      frame_done <= vs_start & v_seen;
      if (vs_start) begin
        frame_bad_eval <= frame_bad | bad_now;
        frame_bad      <= 1'b0;
      end else begin
        frame_bad <= frame_bad | bad_now;
      end
      if (h_lost | eval_bad) begin
        good_run <= 2'd0;
        locked   <= 1'b0;
      end else if (frame_done) begin
        good_run <= (good_run == 2'd2) ? 2'd2 : good_run + 2'd1;
        locked   <= (good_run != 2'd0);
      end
      if (h_lost | eval_bad) timing_err <= 1'b1;
      else if (err_clr)      timing_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced 40x20 video mode;
// a second instance with SYNC_POL=1 sees the same stimulus with inverted syncs.
module tb_vga_timing_monitor;

  localparam int HT  = 40;
  localparam int HSW = 6;
  localparam int VT  = 20;
  localparam int VSW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs, vs, err_clr;
  logic        hs_p, vs_p;
  logic [11:0] rgb;

  logic [11:0] a_h_total, a_h_sync, a_v_total, a_v_sync, a_lit;
  logic        a_done, a_locked, a_err;
  logic [11:0] b_h_total, b_h_sync, b_v_total, b_v_sync, b_lit;
  logic        b_done, b_locked, b_err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_a = 0;
  int done_b = 0;
  int snap;

  assign hs_p = ~hs;
  assign vs_p = ~vs;

  always #5 clk = ~clk;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HSW), .V_TOTAL(VT), .V_SYNC(VSW), .SYNC_POL(0), .CNT_W(12)
  ) dut (
    .pixel_clk(clk), .rst(rst), .VGA_HS(hs), .VGA_VS(vs),
    .VGA_R(rgb[11:8]), .VGA_G(rgb[7:4]), .VGA_B(rgb[3:0]), .err_clr(err_clr),
    .h_total_meas(a_h_total), .h_sync_meas(a_h_sync), .v_total_meas(a_v_total),
    .v_sync_meas(a_v_sync), .lit_lines(a_lit), .frame_done(a_done),
    .locked(a_locked), .timing_err(a_err)
  );

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HSW), .V_TOTAL(VT), .V_SYNC(VSW), .SYNC_POL(1), .CNT_W(12)
  ) dut_pos (
    .pixel_clk(clk), .rst(rst), .VGA_HS(hs_p), .VGA_VS(vs_p),
    .VGA_R(rgb[11:8]), .VGA_G(rgb[7:4]), .VGA_B(rgb[3:0]), .err_clr(err_clr),
    .h_total_meas(b_h_total), .h_sync_meas(b_h_sync), .v_total_meas(b_v_total),
    .v_sync_meas(b_v_sync), .lit_lines(b_lit), .frame_done(b_done),
    .locked(b_locked), .timing_err(b_err)
  );

  always @(negedge clk) begin
    if (a_done) done_a++;
    if (b_done) done_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hs = 1'b1; vs = 1'b1; rgb = 12'h000; err_clr = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One line: hsync on pixels 0..hsw-1, active video on pixels 10..33.
  task automatic drive_line(input bit vs_on, input bit lit, input int hsw, input bit clr);
    for (int p = 0; p < HT; p++) begin
      hs      = (p < hsw) ? 1'b0 : 1'b1;
      vs      = vs_on ? 1'b0 : 1'b1;
      rgb     = (lit && p >= 10 && p < 34) ? 12'h5A3 : 12'h000;
      err_clr = clr && (p == 20);
      tick();
    end
    err_clr = 1'b0;
  endtask

  // Lines l0..l1-1 of a frame: vsync on lines 0-1, lit lines 4..15 minus the
  // first 'black' of them, optional narrow hsync on bad_line, err_clr on line 10.
  task automatic drive_frame(input int l0, input int l1, input int bad_line,
                             input int black, input bit clr);
    for (int l = l0; l < l1; l++)
      drive_line(l < VSW, (l >= 4) && (l < 16) && (l - 4 >= black),
                 (l == bad_line) ? HSW - 1 : HSW, clr && (l == 10));
  endtask

  initial begin
    rst = 1'b0;
    hs = 1'b1; vs = 1'b1; rgb = 12'h000; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_h_total", a_h_total, 0);
    check("rst_locked", a_locked, 0);
    check("rst_err", a_err, 0);
    check("rst_done", a_done, 0);
    rst = 1'b1;
    idle(5);

    // Nominal: three frames, frame_done at vs_start #2 and #3
    repeat (3) drive_frame(0, VT, -1, 0, 1'b0);
    check("nom_h_total", a_h_total, 40);
    check("nom_h_sync", a_h_sync, 6);
    check("nom_v_total", a_v_total, 20);
    check("nom_v_sync", a_v_sync, 2);
    check("nom_lit", a_lit, 12);
    check("nom_done_cnt", done_a, 2);
    check("nom_locked", a_locked, 1);
    check("nom_err", a_err, 0);
    check("pol1_h_total", b_h_total, 40);
    check("pol1_h_sync", b_h_sync, 6);
    check("pol1_v_total", b_v_total, 20);
    check("pol1_v_sync", b_v_sync, 2);
    check("pol1_lit", b_lit, 12);
    check("pol1_done_cnt", done_b, 2);
    check("pol1_locked", b_locked, 1);

    // Narrow hsync on the last line of frame 4, flagged at the next frame start
    drive_frame(0, VT, VT - 1, 0, 1'b0);
    check("narrow_h_sync", a_h_sync, 5);
    check("narrow_locked_before_eval", a_locked, 1);
    check("narrow_err_before_eval", a_err, 0);
    drive_frame(0, VT, -1, 0, 1'b0);
    check("bad_locked", a_locked, 0);
    check("bad_err", a_err, 1);
    check("bad_done_cnt", done_a, 4);
    check("bad_h_sync_restored", a_h_sync, 6);

    // err_clr mid-frame, then relock after two good frames
    drive_frame(0, VT, -1, 0, 1'b1);
    check("clr_err", a_err, 0);
    check("clr_locked", a_locked, 0);
    drive_frame(0, VT, -1, 0, 1'b0);
    check("relock_locked", a_locked, 1);
    check("relock_err", a_err, 0);
    check("relock_done_cnt", done_a, 6);

    // Three black lines at the top of the active area
    drive_frame(0, VT, -1, 3, 1'b0);
    check("black_prev_lit", a_lit, 12);
    drive_frame(0, VT, -1, 0, 1'b0);
    check("black_lit", a_lit, 9);
    check("black_locked", a_locked, 1);

    // Loss of hsync
    idle(4200);
    check("loss_locked", a_locked, 0);
    check("loss_err", a_err, 1);
    snap = done_a;
    drive_frame(0, 1, -1, 0, 1'b0);
    check("loss_first_hs_no_latch", a_h_total, 40);
    drive_frame(1, VT, -1, 0, 1'b0);
    check("loss_no_done", done_a, snap);
    check("loss_h_total", a_h_total, 40);
    drive_frame(0, VT, -1, 0, 1'b0);
    check("loss_done_after_frame", done_a, snap + 1);
    check("loss_v_total", a_v_total, 20);
    check("loss_err_sticky", a_err, 1);

    // Reset mid-frame
    drive_frame(0, 10, -1, 0, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_h_total", a_h_total, 0);
    check("mid_rst_v_total", a_v_total, 0);
    check("mid_rst_lit", a_lit, 0);
    check("mid_rst_err", a_err, 0);
    idle(3);
    rst = 1'b1;
    snap = done_a;
    drive_frame(10, VT, -1, 0, 1'b0);
    drive_frame(0, VT, -1, 0, 1'b0);
    check("post_rst_no_done", done_a, snap);
    drive_frame(0, VT, -1, 0, 1'b0);
    check("post_rst_done", done_a, snap + 1);
    check("post_rst_h_total", a_h_total, 40);
    check("post_rst_h_sync", a_h_sync, 6);
    check("post_rst_v_total", a_v_total, 20);
    check("post_rst_v_sync", a_v_sync, 2);
    check("post_rst_lit", a_lit, 12);
    check("post_rst_locked", a_locked, 0);
    check("post_rst_err", a_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
